// File: rtl/dmem_responder_if.sv
// Request/done handshake between the CPU Memory stage and the data memory.
interface dmem_responder_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ready;
   logic        done;
   logic [31:0] rdata;
   logic        err;

   // CPU side: issues requests, observes completion
   modport master (
      output req, we, addr, wdata,
      input  ready, done, rdata, err
   );

   // Memory side: accepts requests, signals completion
   modport slave (
      input  req, we, addr, wdata,
      output ready, done, rdata, err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed-latency single-outstanding
// request/done handshake. Faults on misaligned or out-of-range addresses.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2
) (
   input  logic             clk,
   input  logic             reset,
   dmem_responder_if.slave  bus
);

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned WIDX_W = ADDR_W - 2;
   localparam int unsigned IDX_W  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [DATA_W-1:0]   mem_array [DEPTH_WORDS];

   logic                fault_c;
   logic [IDX_W-1:0]    idx_c;
   logic                mem_we_c;
   logic [DATA_W-1:0]   rd_word_c;

   // Fault check runs on the full word-index field so large addresses never alias
   always_comb begin
      fault_c = (addr_q[1:0] != 2'b00) ||
                (addr_q[ADDR_W-1:2] >= WIDX_W'(DEPTH_WORDS));
      idx_c     = addr_q[IDX_W+1:2];
      rd_word_c = mem_array[idx_c];
   end

   // Next-state and registered-output computation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rdata_d  = '0;
      mem_we_c = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.req) begin
               we_d    = bus.we;
               addr_d  = bus.addr;
               wdata_d = bus.wdata;
               cnt_d   = CNT_W'(LATENCY - 1);
               state_d = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (cnt_q == '0) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               err_d   = fault_c;
               if (!fault_c) begin
                  if (we_q) begin
                     mem_we_c = 1'b1;
                  end else begin
                     rdata_d = rd_word_c;
                  end
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and output registers; reset abandons any in-flight access
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Storage array, not cleared by reset; full-word stores only
   always_ff @(posedge clk) begin
      if (mem_we_c) begin
         mem_array[idx_c] <= wdata_q;
      end
   end

   assign bus.ready = (state_q == ST_IDLE) && !reset;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=15 instances for timing corners.
module tb_dmem_responder;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_mis;

   dmem_responder_if b2 ();
   dmem_responder_if b1 ();
   dmem_responder_if b15 ();

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2))  u_l2  (.clk(clk), .reset(reset), .bus(b2));
   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1))  u_l1  (.clk(clk), .reset(reset), .bus(b1));
   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) u_l15 (.clk(clk), .reset(reset), .bus(b15));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_cmp++;
      assert (observed === expected)
      else begin
         n_mis++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // sel: 0 = LATENCY 2, 1 = LATENCY 1, 2 = LATENCY 15
   task automatic drive(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
      case (sel)
         1:       begin b1.req  = r; b1.we  = w; b1.addr  = a; b1.wdata  = d; end
         2:       begin b15.req = r; b15.we = w; b15.addr = a; b15.wdata = d; end
         default: begin b2.req  = r; b2.we  = w; b2.addr  = a; b2.wdata  = d; end
      endcase
   endtask

   // which: 0 ready, 1 done, 2 err, 3 rdata
   function automatic logic [31:0] obs(input int sel, input int which);
      logic [31:0] v;
      v = '0;
      case (sel)
         1: case (which)
               0: v = 32'(b1.ready);  1: v = 32'(b1.done);
               2: v = 32'(b1.err);    default: v = b1.rdata;
            endcase
         2: case (which)
               0: v = 32'(b15.ready); 1: v = 32'(b15.done);
               2: v = 32'(b15.err);   default: v = b15.rdata;
            endcase
         default: case (which)
               0: v = 32'(b2.ready);  1: v = 32'(b2.done);
               2: v = 32'(b2.err);    default: v = b2.rdata;
            endcase
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction, called 1 time unit after an edge with the DUT idle
   task automatic access(input int sel, input int lat, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_rdata, input logic exp_err,
                         input string tag);
      drive(sel, 1'b1, w, a, d);
      tick();
      chk({tag, ".ready_e0"}, obs(sel, 0), 32'd0);
      drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
      for (int i = 1; i < lat; i++) begin
         tick();
         chk($sformatf("%s.done_e%0d", tag, i), obs(sel, 1), 32'd0);
      end
      tick();
      chk({tag, ".done"},  obs(sel, 1), 32'd1);
      chk({tag, ".err"},   obs(sel, 2), 32'(exp_err));
      chk({tag, ".rdata"}, obs(sel, 3), exp_rdata);
      chk({tag, ".ready_done"}, obs(sel, 0), 32'd0);
      tick();
      chk({tag, ".done_after"},  obs(sel, 1), 32'd0);
      chk({tag, ".ready_after"}, obs(sel, 0), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_mis = 0;
      reset = 1'b1;
      drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
      drive(2, 1'b0, 1'b0, 32'd0, 32'd0);

      // Reset state
      tick();
      tick();
      chk("rst.ready", obs(0, 0), 32'd0);
      chk("rst.done",  obs(0, 1), 32'd0);
      chk("rst.err",   obs(0, 2), 32'd0);
      chk("rst.rdata", obs(0, 3), 32'd0);
      reset = 1'b0;
      #1;
      chk("rst.ready_release", obs(0, 0), 32'd1);
      tick();

      // Basic write then read-back
      access(0, 2, 1'b1, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, "wr10");
      access(0, 2, 1'b0, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, "rd10");

      // Fault cases and the top word
      access(0, 2, 1'b0, 32'h12, 32'd0, 32'd0, 1'b1, "rd_misalign");
      access(0, 2, 1'b1, 32'h3FC, 32'h5, 32'd0, 1'b0, "wr_top");
      access(0, 2, 1'b0, 32'h3FC, 32'd0, 32'h5, 1'b0, "rd_top");
      access(0, 2, 1'b1, 32'h0, 32'h0BADF00D, 32'd0, 1'b0, "wr0");
      access(0, 2, 1'b1, 32'h400, 32'h12345678, 32'd0, 1'b1, "wr_oob");
      access(0, 2, 1'b1, 32'h4000_0000, 32'h87654321, 32'd0, 1'b1, "wr_far");
      access(0, 2, 1'b0, 32'h0, 32'd0, 32'h0BADF00D, 1'b0, "rd0_unchanged");

      // req held high: accepts every 4 edges, alternating write/read of 0x20
      drive(0, 1'b1, 1'b1, 32'h20, 32'h11);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("hold%0d.ready_e0", k), obs(0, 0), 32'd0);
         if (k == 0)      drive(0, 1'b1, 1'b0, 32'h20, 32'h0);
         else if (k == 1) drive(0, 1'b1, 1'b1, 32'h20, 32'h22);
         else             drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
         chk($sformatf("hold%0d.done_e1", k), obs(0, 1), 32'd0);
         tick();
         chk($sformatf("hold%0d.done_e2", k), obs(0, 1), 32'd1);
         chk($sformatf("hold%0d.rdata", k), obs(0, 3), (k == 1) ? 32'h11 : 32'h0);
         tick();
         chk($sformatf("hold%0d.done_e3", k), obs(0, 1), 32'd0);
         chk($sformatf("hold%0d.ready_e3", k), obs(0, 0), 32'd1);
      end
      access(0, 2, 1'b0, 32'h20, 32'd0, 32'h22, 1'b0, "rd20");

      // Request pulsed while busy/done is ignored
      access(0, 2, 1'b1, 32'h30, 32'hAAAA, 32'd0, 1'b0, "pre30");
      drive(0, 1'b1, 1'b0, 32'h10, 32'd0);
      tick();
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      drive(0, 1'b1, 1'b1, 32'h30, 32'h1);
      tick();
      chk("ign.done",  obs(0, 1), 32'd1);
      chk("ign.rdata", obs(0, 3), 32'hDEADBEEF);
      tick();
      chk("ign.done_e3",  obs(0, 1), 32'd0);
      chk("ign.ready_e3", obs(0, 0), 32'd1);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      chk("ign.no_extra_done", obs(0, 1), 32'd0);
      chk("ign.ready_e4",      obs(0, 0), 32'd1);
      tick();
      chk("ign.no_extra_done2", obs(0, 1), 32'd0);
      access(0, 2, 1'b0, 32'h30, 32'd0, 32'hAAAA, 1'b0, "rd30");

      // Reset during a write abandons it
      access(0, 2, 1'b1, 32'h40, 32'h1234, 32'd0, 1'b0, "pre40");
      drive(0, 1'b1, 1'b1, 32'h40, 32'h9999);
      tick();
      chk("rstmid.ready_e0", obs(0, 0), 32'd0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      reset = 1'b1;
      #1;
      chk("rstmid.ready_async", obs(0, 0), 32'd0);
      chk("rstmid.done_async",  obs(0, 1), 32'd0);
      tick();
      chk("rstmid.done_e2",  obs(0, 1), 32'd0);
      chk("rstmid.ready_e2", obs(0, 0), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      chk("rstmid.ready_release", obs(0, 0), 32'd1);
      tick();
      chk("rstmid.done_after", obs(0, 1), 32'd0);
      access(0, 2, 1'b0, 32'h40, 32'd0, 32'h1234, 1'b0, "rd40");

      // Latency corners
      access(1, 1, 1'b1, 32'h0, 32'h77, 32'd0, 1'b0, "l1.wr0");
      access(1, 1, 1'b0, 32'h0, 32'd0, 32'h77, 1'b0, "l1.rd0");
      access(2, 15, 1'b1, 32'h0, 32'h99, 32'd0, 1'b0, "l15.wr0");
      access(2, 15, 1'b0, 32'h0, 32'd0, 32'h99, 1'b0, "l15.rd0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
